sram_like_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_grant.sv | 32 +++
 rtl/sram_like_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM-like two-master arbiter.
// Consumed by sram_arb_grant and by the sram_like_arbiter top.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant selection between the inst and data masters.
// Build option SRAM_ARB_ROUND_ROBIN_EN: on a tie, the master not granted last wins.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_owner_o
);

    assign grant_valid_o = inst_req_i | data_req_i;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        if (inst_req_i && data_req_i) begin
            grant_owner_o = (last_grant_i == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req_i) begin
            grant_owner_o = OWN_DATA;
        end else begin
            grant_owner_o = OWN_INST;
        end
    end
`else
    // Fixed priority: history is irrelevant here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_owner_o     = data_req_i ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data SRAM-like ports onto one downstream port, one transaction at a time.
// Build option SRAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: data wins).
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              inst_req_i,
    input  logic              inst_wr_i,
    input  logic [1:0]        inst_size_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [DATA_W-1:0] inst_wdata_i,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    output logic [DATA_W-1:0] inst_rdata_o,

    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic [DATA_W-1:0] data_rdata_o,

    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [1:0]        bus_size_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_wr_q, bus_wr_d;
    logic [1:0]          bus_size_q, bus_size_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

    logic                grant_valid;
    logic                grant_owner;
    logic                last_grant;

    logic                sel_wr;
    logic [1:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = OWN_INST;
`endif

    sram_arb_grant u_grant (
        .inst_req_i    (inst_req_i),
        .data_req_i    (data_req_i),
        .last_grant_i  (last_grant),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_comb begin
        if (grant_owner == OWN_DATA) begin
            sel_wr    = data_wr_i;
            sel_size  = data_size_i;
            sel_addr  = data_addr_i;
            sel_wdata = data_wdata_i;
        end else begin
            sel_wr    = inst_wr_i;
            sel_size  = inst_size_i;
            sel_addr  = inst_addr_i;
            sel_wdata = inst_wdata_i;
        end
    end

    // Request fields are captured only at grant, so master-side changes cannot disturb REQ.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req_d   = bus_req_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d     = S_REQ;
                    owner_d     = grant_owner;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = sel_wr;
                    bus_size_d  = sel_size;
                    bus_addr_d  = sel_addr;
                    bus_wdata_d = sel_wdata;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_owner;
`endif
                end
            end
            S_REQ: begin
                if (bus_addr_ok_i) begin
                    state_d   = S_DATA;
                    bus_req_d = 1'b0;
                end
            end
            S_DATA: begin
                if (bus_data_ok_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_INST;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= SZ_BYTE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= OWN_INST;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Slave handshakes are honoured only in their own state and routed to the owner alone.
    logic addr_ok_fire;
    logic data_ok_fire;

    assign addr_ok_fire = (state_q == S_REQ)  && bus_addr_ok_i;
    assign data_ok_fire = (state_q == S_DATA) && bus_data_ok_i;

    assign inst_addr_ok_o = addr_ok_fire && (owner_q == OWN_INST);
    assign data_addr_ok_o = addr_ok_fire && (owner_q == OWN_DATA);
    assign inst_data_ok_o = data_ok_fire && (owner_q == OWN_INST);
    assign data_data_ok_o = data_ok_fire && (owner_q == OWN_DATA);

    assign inst_rdata_o = bus_rdata_i;
    assign data_rdata_o = bus_rdata_i;

    assign bus_req_o   = bus_req_q;
    assign bus_wr_o    = bus_wr_q;
    assign bus_size_o  = bus_size_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
